cpu_run_ctrl: RTL and testbench

- Run/stall sequencer for the Harvard MIPS datapath.
- Owns the CPU lifecycle: reset hold, one-cycle boot load of the reset vector into the PC, normal run, memory-wait stalls, halt on jump-to-zero, and a stall-timeout error.
- Drives the clk_enable of every flipflopr-based PC and pipeline register and gates the register-file write enable, so that v0 is frozen at halt.

---
 rtl/cpu_run_ctrl_pkg.sv | 24 ++
 rtl/cpu_run_ctrl_if.sv | 33 +++
 rtl/cpu_run_ctrl_stall_timer.sv | 43 ++++
 rtl/cpu_run_ctrl.sv | 119 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and address constants for the CPU run/stall
// sequencer. The reset vector and halt address defaults are also used by the
// datapath PC-next mux so both sides agree on the boot and stop addresses.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        RST   = 3'd0,
        BOOT  = 3'd1,
        RUN   = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4,
        ERROR = 3'd5
    } run_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

    // A data stall only counts when the current instruction touches data memory.
    function automatic logic stall_of(input logic instr_wait, input logic rd,
                                      input logic wr, input logic data_wait);
        return instr_wait | ((rd | wr) & data_wait);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: datapath <-> run controller signal bundle.
//   master : datapath side, drives clk_enable, wait requests, data access
//            flags and pc_current; receives the enables and status.
//   slave  : controller side (cpu_run_ctrl).
//   stall_cycles is CNT_W wide and must match the controller's CNT_W.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             clk_enable;
    logic             instr_waitrequest;
    logic             data_read;
    logic             data_write;
    logic             data_waitrequest;
    logic [31:0]      pc_current;
    logic             boot_sel;
    logic             stage_en;
    logic             rf_we_en;
    logic             active;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output clk_enable, instr_waitrequest, data_read, data_write,
               data_waitrequest, pc_current,
        input  boot_sel, stage_en, rf_we_en, active, timeout_err, stall_cycles
    );

    modport slave (
        input  clk_enable, instr_waitrequest, data_read, data_write,
               data_waitrequest, pc_current,
        output boot_sel, stage_en, rf_we_en, active, timeout_err, stall_cycles
    );
endinterface

// File: rtl/cpu_run_ctrl_stall_timer.sv
// stall_timer: consecutive-stall counter plus saturating total-stall counter.
//   clk, reset : rising-edge clock, synchronous active-low reset (clears both)
//   en         : global enable; both counters hold when low
//   clr        : clear the consecutive counter (non-stalled advance)
//   inc        : one more stalled cycle (bumps both counters)
//   tc         : consecutive count has reached TIMEOUT-1
//   total      : total stalled cycles since reset, sticks at all-ones
module stall_timer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic             tc,
    output logic [CNT_W-1:0] total
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0]    consec_q;
    logic [CNT_W-1:0] total_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            consec_q <= '0;
            total_q  <= '0;
        end else if (en) begin
            if (clr) begin
                consec_q <= '0;
            end else if (inc) begin
                consec_q <= consec_q + CW'(1);
            end
            if (inc && (total_q != '1)) begin
                total_q <= total_q + CNT_W'(1);
            end
        end
    end

    assign tc    = (consec_q == CW'(TIMEOUT - 1));
    assign total = total_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stall sequencer for the Harvard MIPS datapath.
// Sequences reset hold, a one-cycle boot load of RESET_VECTOR, normal run,
// memory-wait stalls, halt on reaching HALT_ADDR and a stall-timeout error.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   bus        : cpu_run_ctrl_if.slave (enables in, PC/stage enables and
//                status out)
//
// state | meaning
// RST   | held in reset, PC mux forced to reset vector, nothing advances
// BOOT  | single cycle, PC loads RESET_VECTOR
// RUN   | executing, last cycle advanced
// WAIT  | executing, last cycle stalled on memory
// HALT  | PC reached HALT_ADDR, frozen until reset
// ERROR | stall lasted TIMEOUT cycles, frozen until reset
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT,
    parameter int          TIMEOUT      = 1024,
    parameter int          CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    cpu_run_ctrl_if.slave      bus
);
    // RESET_VECTOR itself is muxed in by the datapath; boot_sel selects it.
    localparam logic [31:0] BOOT_PC = RESET_VECTOR;

    run_state_t state_q, state_d;
    logic       stall, at_halt, tc, t_clr, t_inc;
    logic       boot_sel, stage_en, rf_we_en, active, timeout_err;
    logic [CNT_W-1:0] total;
    logic       unused_boot_pc;

    assign unused_boot_pc = ^BOOT_PC;

    assign stall   = stall_of(bus.instr_waitrequest, bus.data_read,
                              bus.data_write, bus.data_waitrequest);
    assign at_halt = (bus.pc_current == HALT_ADDR);

    stall_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (bus.clk_enable),
        .clr   (t_clr),
        .inc   (t_inc),
        .tc    (tc),
        .total (total)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_clr   = 1'b0;
        t_inc   = 1'b0;
        if (bus.clk_enable) begin
            case (state_q)
                RST:  state_d = BOOT;
                BOOT: state_d = RUN;
                RUN, WAIT: begin
                    // Halt wins over a pending stall so the halted PC never advances.
                    if (at_halt) begin
                        state_d = HALT;
                    end else if (stall && tc) begin
                        state_d = ERROR;
                    end else if (stall) begin
                        state_d = WAIT;
                        t_inc   = 1'b1;
                    end else begin
                        state_d = RUN;
                        t_clr   = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        boot_sel    = 1'b0;
        stage_en    = 1'b0;
        rf_we_en    = 1'b0;
        active      = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            RST: boot_sel = 1'b1;
            BOOT: begin
                boot_sel = 1'b1;
                stage_en = bus.clk_enable;
                active   = 1'b1;
            end
            RUN, WAIT: begin
                active   = 1'b1;
                stage_en = bus.clk_enable & ~stall & ~at_halt;
                rf_we_en = stage_en;
            end
            ERROR:   timeout_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.boot_sel     = boot_sel;
    assign bus.stage_en     = stage_en;
    assign bus.rf_we_en     = rf_we_en;
    assign bus.active       = active;
    assign bus.timeout_err  = timeout_err;
    assign bus.stall_cycles = total;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
    localparam int TO = 8;
    localparam logic [31:0] PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(32)) bus ();
    cpu_run_ctrl_if #(.CNT_W(4))  bus4 ();

    cpu_run_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    cpu_run_ctrl #(.TIMEOUT(TO), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    assign bus4.clk_enable        = bus.clk_enable;
    assign bus4.instr_waitrequest = bus.instr_waitrequest;
    assign bus4.data_read         = bus.data_read;
    assign bus4.data_write        = bus.data_write;
    assign bus4.data_waitrequest  = bus.data_waitrequest;
    assign bus4.pc_current        = bus.pc_current;

    wire [4:0] obs_o  = {bus.boot_sel, bus.stage_en, bus.rf_we_en, bus.active, bus.timeout_err};
    wire [4:0] obs4_o = {bus4.boot_sel, bus4.stage_en, bus4.rf_we_en, bus4.active, bus4.timeout_err};

    int total_cnt = 0;
    int bad = 0;

    // Reference model: lifecycle flags plus plain integer stall counts.
    bit     m_rst = 1'b1, m_boot = 1'b0, m_halt = 1'b0, m_err = 1'b0;
    int     m_consec = 0;
    longint m_total = 0;
    logic [4:0]  exp_o;
    logic [31:0] exp_sc;
    logic [3:0]  exp_sc4;

    function automatic bit cur_stall();
        return bus.instr_waitrequest || ((bus.data_read || bus.data_write) && bus.data_waitrequest);
    endfunction

    function void model_eval();
        bit ce, adv;
        ce = bus.clk_enable;
        if (m_rst)                exp_o = 5'b10000;
        else if (m_boot)          exp_o = {1'b1, ce, 1'b0, 1'b1, 1'b0};
        else if (m_halt || m_err) exp_o = {4'b0000, m_err};
        else begin
            adv   = ce && !cur_stall() && (bus.pc_current != 32'h0);
            exp_o = {1'b0, adv, adv, 1'b1, 1'b0};
        end
        exp_sc  = m_total[31:0];
        exp_sc4 = (m_total > 15) ? 4'd15 : m_total[3:0];
    endfunction

    function void model_step();
        if (!reset) begin
            m_rst = 1; m_boot = 0; m_halt = 0; m_err = 0; m_consec = 0; m_total = 0;
        end else if (!bus.clk_enable) begin
            m_rst = m_rst;
        end else if (m_rst) begin
            m_rst = 0; m_boot = 1;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_halt && !m_err) begin
            if (bus.pc_current == 32'h0) m_halt = 1;
            else if (cur_stall()) begin
                if (m_consec + 1 >= TO) m_err = 1;
                else begin m_consec++; m_total++; end
            end else m_consec = 0;
        end
    endfunction

    // One cycle: let the edge happen, then apply new inputs mid-cycle.
    task automatic drive(input bit rst, input bit ce, input bit iw, input bit dr,
                         input bit dw, input bit dwr, input logic [31:0] pc);
        @(posedge clk);
        model_step();
        @(negedge clk);
        reset = rst;
        bus.clk_enable = ce;
        bus.instr_waitrequest = iw;
        bus.data_read = dr;
        bus.data_write = dw;
        bus.data_waitrequest = dwr;
        bus.pc_current = pc;
        #1;
        model_eval();
    endtask

    task automatic do_boot();
        drive(0, 1, 0, 0, 0, 0, PC);
        drive(0, 1, 0, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, PC);
            total_cnt++; if (obs_o !== 5'b10000) begin bad++; $display("FAIL rst_out obs=%b exp=%b", obs_o, 5'b10000); end
            total_cnt++; if (bus.stall_cycles !== exp_sc) begin bad++; $display("FAIL rst_sc obs=%0d exp=%0d", bus.stall_cycles, exp_sc); end
        end
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== exp_o) begin bad++; $display("FAIL rel_out obs=%b exp=%b", obs_o, exp_o); end
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b11010) begin bad++; $display("FAIL boot_out obs=%b exp=%b", obs_o, 5'b11010); end
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b01110) begin bad++; $display("FAIL run_out obs=%b exp=%b", obs_o, 5'b01110); end
        total_cnt++; if (bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL run_sc obs=%0d exp=0", bus.stall_cycles); end
    endtask

    task automatic test_data_stall();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 1, PC);
            total_cnt++; if (obs_o[3:2] !== 2'b00 || obs_o !== exp_o) begin bad++; $display("FAIL dstall_out cyc=%0d obs=%b exp=%b", i, obs_o, exp_o); end
        end
        drive(1, 1, 0, 1, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b01110) begin bad++; $display("FAIL dstall_resume obs=%b exp=%b", obs_o, 5'b01110); end
        total_cnt++; if (bus.stall_cycles !== 32'd5) begin bad++; $display("FAIL dstall_sc obs=%0d exp=5", bus.stall_cycles); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TO - 1; i++) drive(1, 1, 1, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b01110) begin bad++; $display("FAIL to_edge_noerr obs=%b exp=%b", obs_o, 5'b01110); end
        for (int i = 0; i < TO; i++) drive(1, 1, 1, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b00001) begin bad++; $display("FAIL to_err obs=%b exp=%b", obs_o, 5'b00001); end
        total_cnt++; if (bus.stall_cycles !== exp_sc) begin bad++; $display("FAIL to_sc obs=%0d exp=%0d", bus.stall_cycles, exp_sc); end
        total_cnt++; if (bus4.stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_sc obs=%0d exp=15", bus4.stall_cycles); end
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b00001) begin bad++; $display("FAIL to_sticky obs=%b exp=%b", obs_o, 5'b00001); end
    endtask

    task automatic test_halt();
        do_boot();
        drive(1, 1, 1, 0, 0, 0, 32'h0);
        total_cnt++; if (obs_o !== 5'b00010) begin bad++; $display("FAIL halt_cycle obs=%b exp=%b", obs_o, 5'b00010); end
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom), $urandom);
            total_cnt++; if (obs_o !== 5'b00000 || bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL halt_hold cyc=%0d obs=%b sc=%0d exp=00000 sc=0", i, obs_o, bus.stall_cycles); end
        end
    endtask

    task automatic test_clk_enable();
        do_boot();
        for (int i = 0; i < 10; i++) begin
            drive(1, !(i >= 3 && i < 7), 0, 0, 1, 1, PC);
            total_cnt++; if (obs_o[3:2] !== 2'b00 || obs_o !== exp_o) begin bad++; $display("FAIL ce_stall cyc=%0d obs=%b exp=%b", i, obs_o, exp_o); end
        end
        drive(1, 1, 0, 0, 1, 0, PC);
        total_cnt++; if (bus.stall_cycles !== 32'd6) begin bad++; $display("FAIL ce_sc obs=%0d exp=6", bus.stall_cycles); end
        total_cnt++; if (obs_o !== 5'b01110) begin bad++; $display("FAIL ce_resume obs=%b exp=%b", obs_o, 5'b01110); end
    endtask

    task automatic test_reset_mid();
        do_boot();
        for (int i = 0; i < 13; i++) drive(1, 1, (i != 6), 0, 0, 0, PC);
        drive(0, 1, 1, 0, 0, 0, PC);
        total_cnt++; if (bus.stall_cycles !== 32'd12 || obs_o !== 5'b00010) begin bad++; $display("FAIL wait_pre obs=%b sc=%0d exp=00010 sc=12", obs_o, bus.stall_cycles); end
        drive(0, 1, 1, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b10000 || bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL wait_rst obs=%b sc=%0d exp=10000 sc=0", obs_o, bus.stall_cycles); end
        drive(1, 1, 0, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b11010) begin bad++; $display("FAIL wait_reboot obs=%b exp=%b", obs_o, 5'b11010); end
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b00000) begin bad++; $display("FAIL halt_pre obs=%b exp=00000", obs_o); end
        drive(0, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b10000) begin bad++; $display("FAIL halt_rst obs=%b exp=10000", obs_o); end
        drive(1, 1, 0, 0, 0, 0, PC);
        drive(1, 1, 0, 0, 0, 0, PC);
        total_cnt++; if (obs_o !== 5'b11010) begin bad++; $display("FAIL halt_reboot obs=%b exp=%b", obs_o, 5'b11010); end
    endtask

    task automatic test_random();
        int bias = 3;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) bias = $urandom_range(1, 10);
            drive($urandom_range(0, 50) != 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 9) < bias, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < bias,
                  ($urandom_range(0, 40) == 0) ? 32'h0 : ($urandom | 32'h4));
            total_cnt++; if (obs_o !== exp_o || obs4_o !== exp_o) begin bad++; $display("FAIL rnd_out cyc=%0d obs=%b obs4=%b exp=%b", i, obs_o, obs4_o, exp_o); end
            total_cnt++; if (bus.stall_cycles !== exp_sc || bus4.stall_cycles !== exp_sc4) begin bad++; $display("FAIL rnd_sc cyc=%0d obs=%0d obs4=%0d exp=%0d exp4=%0d", i, bus.stall_cycles, bus4.stall_cycles, exp_sc, exp_sc4); end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.clk_enable = 1'b1;
        bus.instr_waitrequest = 1'b0;
        bus.data_read = 1'b0;
        bus.data_write = 1'b0;
        bus.data_waitrequest = 1'b0;
        bus.pc_current = PC;
        test_reset();
        test_data_stall();
        test_timeout();
        test_halt();
        test_clk_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad);
        $finish;
    end
endmodule
